// File: rtl/ha2.sv
// Registered, vectorised half adder: per-lane sum/carry delivered PIPE cycles
// after sampling, with a saturating count of results that carried in any lane.
module ha2 #(
    parameter int WIDTH = 1,
    parameter int PIPE  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             clr_cnt,
    output logic             out_valid,
    output logic [WIDTH-1:0] Su,
    output logic [WIDTH-1:0] Ca,
    output logic             carry_any,
    output logic [CNT_W-1:0] carry_cnt
);

    generate
        if (PIPE < 1 || PIPE > 4 || WIDTH < 1 || CNT_W < 2) begin : g_bad_params
            $error("ha2: illegal parameters WIDTH=%0d PIPE=%0d CNT_W=%0d", WIDTH, PIPE, CNT_W);
        end
    endgenerate

    logic [PIPE-1:0]  vld_q;
    logic [WIDTH-1:0] su_q [PIPE];
    logic [WIDTH-1:0] ca_q [PIPE];
    logic [CNT_W-1:0] cnt_q;

    // Data stages load every cycle; only the valid bit marks bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < PIPE; i++) begin
                su_q[i] <= '0;
                ca_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            su_q[0]  <= A ^ B;
            ca_q[0]  <= A & B;
            for (int i = 1; i < PIPE; i++) begin
                vld_q[i] <= vld_q[i-1];
                su_q[i]  <= su_q[i-1];
                ca_q[i]  <= ca_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[PIPE-1];
    assign Su        = su_q[PIPE-1];
    assign Ca        = ca_q[PIPE-1];
    assign carry_any = |ca_q[PIPE-1];

    // Counts at the output stage; clear beats a coincident increment.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            cnt_q <= '0;
        end else if (out_valid && carry_any && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign carry_cnt = cnt_q;

endmodule

// File: tb/tb_ha2.sv
// Bench for ha2: three instances (PIPE 1/3/4, one with a 2-bit counter) share
// stimulus; a per-instance expected queue models the pipeline and counter.
module tb_ha2;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       clr_cnt;
    logic [3:0] a;
    logic [3:0] b;

    logic        v1, any1, v3, any3, v4, any4;
    logic [0:0]  su1, ca1;
    logic [3:0]  su3, ca3, su4, ca4;
    logic [15:0] cnt1, cnt4;
    logic [1:0]  cnt3;

    ha2 #(.WIDTH(1), .PIPE(1), .CNT_W(16)) u_p1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(a[0:0]), .B(b[0:0]),
        .clr_cnt(clr_cnt), .out_valid(v1), .Su(su1), .Ca(ca1),
        .carry_any(any1), .carry_cnt(cnt1)
    );

    ha2 #(.WIDTH(4), .PIPE(3), .CNT_W(2)) u_p3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b),
        .clr_cnt(clr_cnt), .out_valid(v3), .Su(su3), .Ca(ca3),
        .carry_any(any3), .carry_cnt(cnt3)
    );

    ha2 #(.WIDTH(4), .PIPE(4), .CNT_W(16)) u_p4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b),
        .clr_cnt(clr_cnt), .out_valid(v4), .Su(su4), .Ca(ca4),
        .carry_any(any4), .carry_cnt(cnt4)
    );

    // Uniform views of the three instances
    logic        o_v   [3];
    logic        o_any [3];
    logic [3:0]  o_su  [3];
    logic [3:0]  o_ca  [3];
    logic [15:0] o_cnt [3];

    assign o_v[0] = v1;  assign o_any[0] = any1;
    assign o_v[1] = v3;  assign o_any[1] = any3;
    assign o_v[2] = v4;  assign o_any[2] = any4;
    assign o_su[0] = {3'b000, su1};  assign o_ca[0] = {3'b000, ca1};
    assign o_su[1] = su3;            assign o_ca[1] = ca3;
    assign o_su[2] = su4;            assign o_ca[2] = ca4;
    assign o_cnt[0] = cnt1;
    assign o_cnt[1] = {14'b0, cnt3};
    assign o_cnt[2] = cnt4;

    int         pipe  [3] = '{1, 3, 4};
    int         cmax  [3] = '{65535, 3, 65535};
    logic [3:0] lmask [3] = '{4'h1, 4'hF, 4'hF};

    // Entry: {valid, su[3:0], ca[3:0]}
    logic [8:0] exp_q [3][$];
    int         exp_cnt [3];

    int n_checks = 0;
    int n_fail   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] mk(input logic v, input logic [3:0] av,
                                      input logic [3:0] bv, input logic [3:0] m);
        return {v, (av ^ bv) & m, (av & bv) & m};
    endfunction

    // Drive one cycle, advance the model at the edge, then compare every instance.
    task automatic step(input logic r, input logic v, input logic [3:0] av,
                        input logic [3:0] bv, input logic c);
        logic [8:0] head;
        rst = r; in_valid = v; a = av; b = bv; clr_cnt = c;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            head = (exp_q[k].size() > 0) ? exp_q[k][0] : 9'h0;
            if (r) begin
                exp_q[k].delete();
                for (int s = 0; s < pipe[k]; s++) exp_q[k].push_back(9'h0);
                exp_cnt[k] = 0;
            end else begin
                if (c)
                    exp_cnt[k] = 0;
                else if (head[8] && (|head[3:0]) && exp_cnt[k] < cmax[k])
                    exp_cnt[k]++;
                exp_q[k].push_back(mk(v, av, bv, lmask[k]));
                void'(exp_q[k].pop_front());
            end
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            head = exp_q[k][0];
            check($sformatf("p%0d_out_valid", pipe[k]), 32'(o_v[k]), 32'(head[8]));
            check($sformatf("p%0d_su", pipe[k]), 32'(o_su[k]), 32'(head[7:4]));
            check($sformatf("p%0d_ca", pipe[k]), 32'(o_ca[k]), 32'(head[3:0]));
            check($sformatf("p%0d_carry_any", pipe[k]), 32'(o_any[k]), 32'(|head[3:0]));
            check($sformatf("p%0d_carry_cnt", pipe[k]), 32'(o_cnt[k]), 32'(exp_cnt[k]));
            check($sformatf("p%0d_su_and_ca", pipe[k]), 32'(o_su[k] & o_ca[k]), 32'd0);
        end
    endtask

    logic [3:0] ra, rb;

    initial begin
        for (int k = 0; k < 3; k++) exp_cnt[k] = 0;
        rst = 1'b1; in_valid = 1'b0; clr_cnt = 1'b0; a = '0; b = '0;

        // Reset held two edges with live operands
        step(1'b1, 1'b1, 4'hF, 4'hF, 1'b0);
        step(1'b1, 1'b1, 4'hF, 4'hF, 1'b0);

        // Truth table on lane 0: (0,0) (0,1) (1,1) (1,0)
        step(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
        step(1'b0, 1'b1, 4'b0100, 4'b1001, 1'b0);
        step(1'b0, 1'b1, 4'b0011, 4'b0001, 1'b0);
        step(1'b0, 1'b1, 4'b1001, 4'b0100, 1'b0);

        // Latency with a bubble between two ops
        step(1'b0, 1'b1, 4'b1100, 4'b1010, 1'b0);
        step(1'b0, 1'b0, 4'b1111, 4'b1111, 1'b0);
        step(1'b0, 1'b1, 4'b0011, 4'b0101, 1'b0);
        repeat (4) step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);

        // Saturation of the 2-bit counter, then clear against a carry result
        step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1);
        repeat (5) step(1'b0, 1'b1, 4'hF, 4'hF, 1'b0);
        repeat (4) step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        step(1'b0, 1'b1, 4'hF, 4'hF, 1'b0);
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
        repeat (4) step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);

        // Carry-free operands leave the counter alone
        repeat (8) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15)) & ~ra;
            step(1'b0, 1'b1, ra, rb, 1'b0);
        end

        // Reset with ops in flight, then one op through the deepest pipe
        repeat (3) step(1'b0, 1'b1, 4'hF, 4'h3, 1'b0);
        step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
        step(1'b0, 1'b1, 4'h6, 4'h7, 1'b0);
        repeat (5) step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);

        // Random traffic with occasional clears
        repeat (60) begin
            step(1'b0, 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 15) == 0));
        end
        repeat (5) step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
